orb_fill_arbiter: RTL

- Write-side controller for the ping-pong orbit frame memory that the orbit serializer drains: 2 banks × 2048 words × 12 bits.
- Shares the write port among NREQ data sources using round-robin arbitration.
- Fills the bank the serializer is not reading, at sequential addresses, one frame per serializer bank toggle.
- Flags frames that were not completely filled before the toggle.

---
 rtl/orb_pkg.sv | 12 +
 rtl/orb_rr_pick.sv | 27 ++
 rtl/orb_fill_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/orb_pkg.sv
// Shared constants and types for the orbit frame-memory write side.
package orb_pkg;
    localparam int ORB_WIDTH       = 12;
    localparam int ORB_AW          = 11;
    localparam int ORB_FRAME_WORDS = 2048;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fillState_t;
endpackage

// File: rtl/orb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, modulo NREQ.
module orb_rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   index,
    output logic            any
);
    always_comb begin
        int pos;
        gnt   = '0;
        index = '0;
        any   = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr) + k) % NREQ;
            if (!any && req[pos]) begin
                any      = 1'b1;
                gnt[pos] = 1'b1;
                index    = PW'(pos);
            end
        end
    end
endmodule

// File: rtl/orb_fill_arbiter.sv
// Round-robin write-port arbiter that fills the orbit bank the serializer is not reading.
// state | meaning
// IDLE  | after reset, waiting for the first bank toggle to align to a frame
// FILL  | granting sources, writing sequential words into the idle bank
// DONE  | frame complete, waiting for the next bank toggle
module orb_fill_arbiter
    import orb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = ORB_WIDTH,
    parameter int AW    = ORB_AW
) (
    input  logic                  iClk,
    input  logic                  reset,
    input  logic                  iSwitch,
    input  logic [NREQ-1:0]       iReq,
    input  logic [NREQ*WIDTH-1:0] iData,
    output logic [NREQ-1:0]       oGnt,
    output logic [AW:0]           oWrAddr,
    output logic [WIDTH-1:0]      oWrData,
    output logic                  oWrEn,
    output logic                  oBusy,
    output logic                  oUnderrun,
    output logic [7:0]            oUnderrunCnt
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

    fillState_t      state, stateNext;
    logic            swQ, toggle, bank;
    logic [AW-1:0]   cnt;
    logic [PW-1:0]   ptr, pickIdx;
    logic [NREQ-1:0] pickGnt;
    logic            pickAny, lastWord, grantOk, underrunHit;

    assign toggle   = iSwitch ^ swQ;
    assign lastWord = &cnt;
    // A toggle only yields to the grant that completes the frame.
    assign grantOk     = (state == FILL) && pickAny && (!toggle || lastWord);
    assign underrunHit = (state == FILL) && toggle && !grantOk;

    orb_rr_pick #(.NREQ(NREQ), .PW(PW)) uPick (
        .req   (iReq),
        .ptr   (ptr),
        .gnt   (pickGnt),
        .index (pickIdx),
        .any   (pickAny)
    );

    always_ff @(posedge iClk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: if (toggle) stateNext = FILL;
            FILL: begin
                if (toggle)                    stateNext = FILL;
                else if (grantOk && lastWord)  stateNext = DONE;
            end
            DONE: if (toggle) stateNext = FILL;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        oBusy = (state == FILL);
        oGnt  = grantOk ? pickGnt : '0;
    end

    always_ff @(posedge iClk or posedge reset) begin
        if (reset) begin
            swQ          <= 1'b0;
            bank         <= 1'b0;
            cnt          <= '0;
            ptr          <= '0;
            oWrEn        <= 1'b0;
            oWrAddr      <= '0;
            oWrData      <= '0;
            oUnderrun    <= 1'b0;
            oUnderrunCnt <= '0;
        end else begin
            swQ       <= iSwitch;
            oWrEn     <= grantOk;
            oUnderrun <= underrunHit;
            // Address uses the pre-toggle bank so an in-flight write lands in the old frame.
            if (grantOk) begin
                oWrAddr <= {bank, cnt};
                oWrData <= iData[pickIdx*WIDTH +: WIDTH];
                ptr     <= (pickIdx == PTR_LAST) ? '0 : pickIdx + 1'b1;
            end
            if (toggle) begin
                bank <= ~iSwitch;
                cnt  <= '0;
            end else if (grantOk && !lastWord) begin
                cnt <= cnt + 1'b1;
            end
            if (underrunHit && oUnderrunCnt != 8'hFF)
                oUnderrunCnt <= oUnderrunCnt + 8'd1;
        end
    end
endmodule
